// File: rtl/dummy_apb_pkg.sv
// +---------------------------------------------------------------+
// | dummy_apb_pkg : register map, CTRL bits, FSM states, STATUS    |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
`default_nettype none

package dummy_apb_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       full;
    logic       empty;
    logic [7:0] count;
  } status_t;

endpackage

`default_nettype wire

// File: rtl/dummy_fifo.sv
// +---------------------------------------------------------------+
// | dummy_fifo : single-port synchronous FIFO with flush           |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
`default_nettype none

module dummy_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/dummy_apb_responder.sv
// +---------------------------------------------------------------+
// | dummy_apb_responder : APB completer with FIFO/CTRL/STATUS/SCR  |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
`default_nettype none

module dummy_apb_responder
  import dummy_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  input  logic                  pwrite_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  output logic                  pready_o,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pslverr_o,
  output logic                  irq_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;

  logic                  fifo_push, fifo_pop, fifo_clr;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  logic                  access;
  logic [1:0]            reg_off;
  logic                  unmapped;
  logic                  acc_err;
  logic                  addr_unused;
  status_t               status;
  logic [DATA_WIDTH-1:0] rd_val;

  assign access      = psel_i & penable_i;
  assign reg_off     = paddr_i[3:2];
  assign unmapped    = |paddr_i[ADDR_WIDTH-1:4];
  assign addr_unused = ^paddr_i[1:0];
  assign irq_o       = en_q & ~fifo_empty;

  assign status.full  = fifo_full;
  assign status.empty = fifo_empty;
  assign status.count = 8'(fifo_count);

  assign acc_err = unmapped
                 | (pwrite_i & (reg_off == REG_STATUS))
                 | ((reg_off == REG_DATA) &
                    (~en_q | (pwrite_i ? fifo_full : fifo_empty)));

  always_comb begin
    rd_val = '0;
    case (reg_off)
      REG_CTRL:    rd_val = DATA_WIDTH'(en_q);
      REG_STATUS:  rd_val = DATA_WIDTH'(status);
      REG_DATA:    rd_val = fifo_rdata;
      REG_SCRATCH: rd_val = scratch_q;
      default:     rd_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    en_d      = en_q;
    scratch_d = scratch_q;
    pready_o  = 1'b0;
    prdata_o  = '0;
    pslverr_o = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            wcnt_d  = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!access) begin
          state_d = IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        // A dropped select/enable here aborts silently: no ready, no commit.
        if (access) begin
          pready_o  = 1'b1;
          pslverr_o = acc_err;
          if (!acc_err) begin
            if (pwrite_i) begin
              case (reg_off)
                REG_CTRL: begin
                  en_d     = pwdata_i[CTRL_EN];
                  fifo_clr = pwdata_i[CTRL_CLR];
                end
                REG_DATA:    fifo_push = 1'b1;
                REG_SCRATCH: scratch_d = pwdata_i;
                default:     ;
              endcase
            end else begin
              prdata_o = rd_val;
              fifo_pop = (reg_off == REG_DATA);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      en_q      <= 1'b0;
      scratch_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      en_q      <= en_d;
      scratch_q <= scratch_d;
    end
  end

  dummy_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .wdata_i (pwdata_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_dummy_apb_responder.sv
// +---------------------------------------------------------------+
// | tb_dummy_apb_responder : directed + random APB bench           |
// | Rev 1.0                                                        |
// +---------------------------------------------------------------+
`default_nettype none

module tb_dummy_apb_responder;

  localparam int WAIT_CYCLES = 1;
  localparam int DEPTH       = 8;

  logic        clk;
  logic        rst;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  bit          m_en;
  logic [31:0] m_scratch;

  dummy_apb_responder #(
    .ADDR_WIDTH  (12),
    .DATA_WIDTH  (32),
    .FIFO_DEPTH  (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .pwrite_i  (pwrite),
    .psel_i    (psel),
    .penable_i (penable),
    .pready_o  (pready),
    .prdata_o  (prdata),
    .pslverr_o (pslverr),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [11:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    int cyc;
    @(negedge clk);
    paddr = a; pwrite = w; pwdata = d; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!pready) check("prdata_idle", prdata, 32'h0);
    end while (!pready && cyc < 20);
    check("latency", cyc, WAIT_CYCLES + 1);
    rd = prdata;
    er = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_access(input string tag, input logic [11:0] a, input logic w,
                           input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] e_rd;
    logic        e_err;
    logic        er;
    int          off;
    bit          unm;
    off   = int'(a[3:2]);
    unm   = (a[11:4] != 8'h0);
    e_err = unm || (w && off == 1) ||
            (off == 2 && (!m_en || (w ? q.size() >= DEPTH : q.size() == 0)));
    e_rd  = 32'h0;
    if (!e_err && !w) begin
      case (off)
        0: e_rd = {31'h0, m_en};
        1: e_rd = {22'h0, q.size() == DEPTH, q.size() == 0, 8'(q.size())};
        2: e_rd = q[0];
        default: e_rd = m_scratch;
      endcase
    end
    xfer(a, w, d, rd, er);
    check({tag, "_err"}, {31'h0, er}, {31'h0, e_err});
    if (!w || e_err) check({tag, "_rdata"}, rd, e_rd);
    if (!e_err) begin
      if (w) begin
        case (off)
          0: begin
            m_en = d[0];
            if (d[1]) q.delete();
          end
          2: q.push_back(d);
          3: m_scratch = d;
          default: ;
        endcase
      end else if (off == 2) begin
        void'(q.pop_front());
      end
    end
    check({tag, "_irq"}, {31'h0, irq}, {31'h0, (m_en && q.size() != 0)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [11:0] a;
    logic        w;
    logic [31:0] d;
    int          sel;

    rst = 1'b1; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
    m_en = 1'b0; m_scratch = '0;
    repeat (3) @(negedge clk);
    check("rst_pready", {31'h0, pready}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", {31'h0, pslverr}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;

    // Scratch round trip
    do_access("scr_wr", 12'hC, 1'b1, 32'hDEADBEEF, rd);
    do_access("scr_rd", 12'hC, 1'b0, 32'h0, rd);
    check("scr_val", rd, 32'hDEADBEEF);

    // Enable, push three, read status, pop three
    do_access("en_wr", 12'h0, 1'b1, 32'h1, rd);
    do_access("push", 12'h8, 1'b1, 32'h11, rd);
    do_access("push", 12'h8, 1'b1, 32'h22, rd);
    do_access("push", 12'h8, 1'b1, 32'h33, rd);
    do_access("st3", 12'h4, 1'b0, 32'h0, rd);
    check("st3_val", rd, 32'h003);
    check("irq_on", {31'h0, irq}, 32'h1);
    do_access("pop", 12'h8, 1'b0, 32'h0, rd); check("pop0", rd, 32'h11);
    do_access("pop", 12'h8, 1'b0, 32'h0, rd); check("pop1", rd, 32'h22);
    do_access("pop", 12'h8, 1'b0, 32'h0, rd); check("pop2", rd, 32'h33);
    do_access("st_empty", 12'h4, 1'b0, 32'h0, rd);
    check("st_empty_val", rd, 32'h100);
    check("irq_off", {31'h0, irq}, 32'h0);

    // Fill to full, overflow, drain across the pointer wrap
    for (int i = 0; i < DEPTH; i++)
      do_access("fill", 12'h8, 1'b1, 32'hA000 + 32'(i), rd);
    do_access("ovf", 12'h8, 1'b1, 32'hBAD, rd);
    do_access("st_full", 12'h4, 1'b0, 32'h0, rd);
    check("st_full_val", rd, 32'h208);
    for (int i = 0; i < DEPTH; i++) begin
      do_access("drain", 12'h8, 1'b0, 32'h0, rd);
      check("drain_val", rd, 32'hA000 + 32'(i));
    end

    // Illegal accesses
    do_access("rd_empty", 12'h8, 1'b0, 32'h0, rd);
    do_access("wr_status", 12'h4, 1'b1, 32'hFFFF, rd);
    do_access("unmapped", 12'h10, 1'b0, 32'h0, rd);
    do_access("dis_wr", 12'h0, 1'b1, 32'h0, rd);
    do_access("push_dis", 12'h8, 1'b1, 32'h55, rd);
    do_access("st_after_err", 12'h4, 1'b0, 32'h0, rd);
    check("st_after_err_val", rd, 32'h100);

    // Flush with EN kept set
    do_access("en_wr2", 12'h0, 1'b1, 32'h1, rd);
    for (int i = 0; i < 4; i++)
      do_access("fill4", 12'h8, 1'b1, 32'hC0 + 32'(i), rd);
    do_access("clr", 12'h0, 1'b1, 32'h3, rd);
    do_access("st_clr", 12'h4, 1'b0, 32'h0, rd);
    check("st_clr_val", rd, 32'h100);
    do_access("ctrl_rd", 12'h0, 1'b0, 32'h0, rd);
    check("ctrl_val", rd, 32'h1);

    // Aborted transfer leaves no trace
    @(negedge clk);
    paddr = 12'hC; pwrite = 1'b1; pwdata = 32'h12345678; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("abort_wait_pready", {31'h0, pready}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("abort_pready", {31'h0, pready}, 32'h0);
    do_access("abort_scr", 12'hC, 1'b0, 32'h0, rd);
    check("abort_scr_val", rd, 32'hDEADBEEF);

    // Reset while a transfer sits in WAIT
    for (int i = 0; i < 3; i++)
      do_access("pre_rst", 12'h8, 1'b1, 32'hE0 + 32'(i), rd);
    @(negedge clk);
    paddr = 12'h4; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_pready", {31'h0, pready}, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    q.delete(); m_en = 1'b0; m_scratch = '0;
    do_access("post_rst_st", 12'h4, 1'b0, 32'h0, rd);
    check("post_rst_st_val", rd, 32'h100);
    do_access("post_rst_ctrl", 12'h0, 1'b0, 32'h0, rd);
    check("post_rst_ctrl_val", rd, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      case (sel)
        0, 1:    a = 12'h0;
        2:       a = 12'h4;
        7:       a = 12'hC;
        8:       a = {8'($urandom_range(1, 255)), 4'($urandom)};
        9:       a = 12'($urandom);
        default: a = 12'h8;
      endcase
      a[1:0] = 2'($urandom);
      if (a[11:2] == 10'h0 && w) begin
        d[0] = ($urandom_range(0, 3) != 0);
        d[1] = ($urandom_range(0, 7) == 0);
      end
      do_access("rnd", a, w, d, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
